perf_counter_bank: RTL
======================

Name: perf_counter_bank

Overview:
Parametrised, synthesizable performance-counter bank for the rasterizer sample-test pipeline. It counts valid samples, sample hits, accepted triangles, enabled cycles and stall cycles. A configurable-depth delay line aligns sample-valid flags with the hit flags emitted PIPE_DEPTH stages later. It adds saturating counters, sync clear, on-demand snapshot and a periodic report pulse, and sits beside the sampletest unit as a testbench/debug tap.

Parameters:
SAMPLES, 4, sample lanes per cycle (1..16)
PIPE_DEPTH, 3, cycles between sample-valid input and hit output (0..15)
CNT_W, 32, width of every counter (8..64)
REPORT_INTERVAL, 100000, samples per report pulse; 0 disables reporting; when non-zero it must be ≥ SAMPLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
en_i  in  1  count enable
clear_i  in  1  synchronous clear of all counters
validSamp_i  in  SAMPLES  per-lane sample valid at the input stage
hit_valid_i  in  SAMPLES  per-lane hit flag at the output stage (PIPE_DEPTH later)
tri_valid_i  in  1  triangle presented to the pipe
tri_halt_i  in  1  pipe stalled; triangle not accepted
snap_req_i  in  1  snapshot request, single-cycle pulse
snap_valid_o  out  1  snapshot registers updated (one-cycle pulse)
snap_sample_o  out  CNT_W  snapshot of sample count
snap_hit_o  out  CNT_W  snapshot of hit count
snap_tri_o  out  CNT_W  snapshot of triangle count
snap_cycle_o  out  CNT_W  snapshot of cycle count
snap_stall_o  out  CNT_W  snapshot of stall count
sat_o  out  5  sticky saturation flags {stall,cycle,tri,hit,sample}
report_o  out  1  one-cycle pulse for each REPORT_INTERVAL samples

Behaviour:
- Reset (rst=0, async): all counters, the delay line, snapshot outputs, sat_o, report_o, snap_valid_o and the report accumulator go to 0.
- Delay line: PIPE_DEPTH-stage register chain on validSamp_i; it shifts every cycle regardless of en_i and clear_i. With PIPE_DEPTH=0 it is a wire. The aligned flag vD[i] is validSamp_i delayed PIPE_DEPTH cycles.
- Per-cycle increments, applied only when en_i=1:
  - sample += popcount(vD)
  - hit += popcount(vD & hit_valid_i)
  - tri += tri_valid_i & ~tri_halt_i
  - stall += tri_valid_i & tri_halt_i
  - cycle += 1
- Width rules: increments are computed in CNT_W+1 bits. If a result exceeds 2^CNT_W−1, the counter holds at all-ones and its sat_o bit sets; the bit stays set until clear_i or reset.
- Counters update on the rising edge and are visible internally one cycle after the inputs.
- clear_i=1: all counters, sat_o and the report accumulator become 0 at the edge. Clear has priority over any same-cycle increment, which is dropped.
- Snapshot: when snap_req_i=1, the next edge copies the pre-edge counter values (the current cycle's increment is excluded) into snap_*_o and pulses snap_valid_o for 1 cycle.
- Snapshot and clear in the same cycle: the snapshot gets the pre-clear values and the counters go to 0. Snapshot outputs hold between requests and are not affected by clear_i.
- Report accumulator (width ≥ log2(REPORT_INTERVAL)+1):
  - acc += popcount(vD) when en_i=1.
  - If the new value ≥ REPORT_INTERVAL, acc takes new−REPORT_INTERVAL (remainder kept) and report_o=1 on the following cycle for exactly 1 cycle.
  - Inactive when REPORT_INTERVAL=0.
  - Saturation of the sample counter does not stop reporting.
- en_i=0: counters and acc hold, but snapshot and clear still act.
- Reset mid-run: outputs go to 0 immediately. In-flight delay-line contents are discarded, so hits of samples issued before reset are not counted.

Test Plan:
- Reset then idle 10 cycles, en_i=1: snap at cycle 10 → snap_cycle=10 (or the exact pre-edge count), all other snapshots 0, sat_o=0.
- PIPE_DEPTH=3, SAMPLES=4: validSamp_i=4'b1011 for 1 cycle, hit_valid_i=4'b0011 exactly 3 cycles later → sample=3, hit=2. The same hit pattern 2 cycles later → hit=0.
- tri_valid_i=1 for 5 cycles with tri_halt_i=1 on cycles 2–3 → tri=3, stall=2.
- CNT_W=8, all lanes valid (SAMPLES=4) for 64 cycles → sample=255, sat_o[0]=1. Then clear_i → sample=0, sat_o=0.
- REPORT_INTERVAL=10, SAMPLES=4, all valid every cycle → report_o pulses once per 2.5 cycles on average: first pulse 1 cycle after the edge where acc reaches 12 (remainder 2).
- snap_req_i and clear_i together after 20 counted cycles → snap_cycle=20, snap_valid_o=1, live counters restart at 0; en_i=0 for 5 cycles → no counter change.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance-counter bank for the rasterizer sample-test pipeline.
// Counts valid samples, sample hits, accepted triangles, enabled cycles and
// stall cycles with saturating counters. It also provides a synchronous
// clear, an on-demand snapshot and a periodic report pulse.
module perf_counter_bank #(
  parameter int SAMPLES         = 4,
  parameter int PIPE_DEPTH      = 3,
  parameter int CNT_W           = 32,
  parameter int REPORT_INTERVAL = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic [SAMPLES-1:0] validSamp_i,
  input  logic [SAMPLES-1:0] hit_valid_i,
  input  logic               tri_valid_i,
  input  logic               tri_halt_i,
  input  logic               snap_req_i,
  output logic               snap_valid_o,
  output logic [CNT_W-1:0]   snap_sample_o,
  output logic [CNT_W-1:0]   snap_hit_o,
  output logic [CNT_W-1:0]   snap_tri_o,
  output logic [CNT_W-1:0]   snap_cycle_o,
  output logic [CNT_W-1:0]   snap_stall_o,
  output logic [4:0]         sat_o,
  output logic               report_o
);

  localparam int POP_W = $clog2(SAMPLES + 1);
  localparam int ACC_W = (REPORT_INTERVAL == 0) ? 2 : $clog2(REPORT_INTERVAL + 1) + 1;

  // Counter slots: 0 sample, 1 hit, 2 tri, 3 cycle, 4 stall (matches sat_o order)
  logic [SAMPLES-1:0]      v_d;
  logic [POP_W-1:0]        samp_pop;
  logic [POP_W-1:0]        hit_pop;
  logic [4:0][CNT_W-1:0]   cnt;
  logic [4:0][CNT_W:0]     inc;
  logic [4:0][CNT_W:0]     sum;

  generate
    if (PIPE_DEPTH == 0) begin : g_no_delay
      assign v_d = validSamp_i;
    end else begin : g_delay
      logic [SAMPLES-1:0] stage [PIPE_DEPTH];

      // Delay the sample-valid flags so they line up with the hit flags
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIPE_DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= validSamp_i;
          for (int i = 1; i < PIPE_DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign v_d = stage[PIPE_DEPTH-1];
    end
  endgenerate

  // Population counts of aligned valid samples and of aligned hits
  always_comb begin
    samp_pop = '0;
    hit_pop  = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      samp_pop += POP_W'(v_d[i]);
      hit_pop  += POP_W'(v_d[i] & hit_valid_i[i]);
    end
  end

  // Per-counter increments and one-bit-wider sums used for overflow detection
  always_comb begin
    inc[0] = (CNT_W+1)'(samp_pop);
    inc[1] = (CNT_W+1)'(hit_pop);
    inc[2] = (CNT_W+1)'(tri_valid_i & ~tri_halt_i);
    inc[3] = (CNT_W+1)'(1);
    inc[4] = (CNT_W+1)'(tri_valid_i & tri_halt_i);
    for (int k = 0; k < 5; k++) sum[k] = {1'b0, cnt[k]} + inc[k];
  end

  // Saturating counters with sticky overflow flags; clear wins over counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      sat_o <= '0;
    end else if (clear_i) begin
      cnt   <= '0;
      sat_o <= '0;
    end else if (en_i) begin
      for (int k = 0; k < 5; k++) begin
        if (sum[k][CNT_W]) begin
          cnt[k]   <= '1;
          sat_o[k] <= 1'b1;
        end else begin
          cnt[k] <= sum[k][CNT_W-1:0];
        end
      end
    end
  end

  // Capture the pre-edge counter values on request; unaffected by clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_valid_o  <= 1'b0;
      snap_sample_o <= '0;
      snap_hit_o    <= '0;
      snap_tri_o    <= '0;
      snap_cycle_o  <= '0;
      snap_stall_o  <= '0;
    end else begin
      snap_valid_o <= snap_req_i;
      if (snap_req_i) begin
        snap_sample_o <= cnt[0];
        snap_hit_o    <= cnt[1];
        snap_tri_o    <= cnt[2];
        snap_cycle_o  <= cnt[3];
        snap_stall_o  <= cnt[4];
      end
    end
  end

  generate
    if (REPORT_INTERVAL == 0) begin : g_no_report
      assign report_o = 1'b0;
    end else begin : g_report
      logic [ACC_W-1:0] acc;
      logic [ACC_W-1:0] acc_next;

      assign acc_next = acc + ACC_W'(samp_pop);

      // Accumulate samples and emit a one-cycle pulse per interval, keeping the remainder
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc      <= '0;
          report_o <= 1'b0;
        end else if (clear_i) begin
          acc      <= '0;
          report_o <= 1'b0;
        end else begin
          report_o <= 1'b0;
          if (en_i) begin
            if (acc_next >= ACC_W'(REPORT_INTERVAL)) begin
              acc      <= acc_next - ACC_W'(REPORT_INTERVAL);
              report_o <= 1'b1;
            end else begin
              acc <= acc_next;
            end
          end
        end
      end
    end
  endgenerate

endmodule
